inst_encoder: RTL and testbench

//  Instruction packer: the inverse of the immediate generator. Takes decoded fields
//  (format select, opcode, registers, funct, 32-bit immediate) and packs a 32-bit RV32I

---
 rtl/inst_encoder.sv | 107 ++++++++++
 tb/tb_inst_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into a 32-bit word through a 2-stage valid/ready pipeline.
// Illegal immediates are replaced by a NOP and counted; each emitted word carries its byte address.
module inst_encoder #(
    parameter int ADDR_W = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        imm_sel_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);
    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I_NONSHIFT = 3'b001;
    localparam logic [2:0] IMM_I_SHIFT = 3'b010;
    localparam logic [2:0] IMM_S = 3'b011;
    localparam logic [2:0] IMM_B = 3'b100;
    localparam logic [2:0] IMM_U = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        v1, ill, ill1, adv2;
    logic [2:0]  sel1, f3_1;
    logic [6:0]  op1, f7_1;
    logic [4:0]  rd1, rs1_1, rs2_1;
    logic [31:0] imm1, packed_w;

    assign adv2 = !out_valid_o || out_ready_i;
    assign in_ready_o = !v1 || adv2;

    // legality is judged on the raw inputs so S2 only has to mux
    always_comb begin
        case (imm_sel_i)
            IMM_R:                 ill = 1'b0;
            IMM_I_NONSHIFT, IMM_S: ill = !(&imm_i[31:11] || ~|imm_i[31:11]);
            IMM_I_SHIFT:           ill = |imm_i[31:5];
            IMM_B:                 ill = !(&imm_i[31:12] || ~|imm_i[31:12]) || imm_i[0];
            IMM_U:                 ill = |imm_i[11:0];
            IMM_J:                 ill = !(&imm_i[31:20] || ~|imm_i[31:20]) || imm_i[0];
            default:               ill = 1'b1;
        endcase
    end

    always_comb begin
        case (sel1)
            IMM_R:          packed_w = {f7_1, rs2_1, rs1_1, f3_1, rd1, op1};
            IMM_I_NONSHIFT: packed_w = {imm1[11:0], rs1_1, f3_1, rd1, op1};
            IMM_I_SHIFT:    packed_w = {f7_1, imm1[4:0], rs1_1, f3_1, rd1, op1};
            IMM_S:          packed_w = {imm1[11:5], rs2_1, rs1_1, f3_1, imm1[4:0], op1};
            IMM_B:          packed_w = {imm1[12], imm1[10:5], rs2_1, rs1_1, f3_1, imm1[4:1], imm1[11], op1};
            IMM_U:          packed_w = {imm1[31:12], rd1, op1};
            IMM_J:          packed_w = {imm1[20], imm1[10:1], imm1[11], imm1[19:12], rd1, op1};
            default:        packed_w = NOP;
        endcase
        if (ill1) packed_w = NOP;
    end

    always_ff @(posedge clk_i) begin
        if (in_ready_o && in_valid_i) begin
            sel1  <= imm_sel_i;
            op1   <= opcode_i;
            rd1   <= rd_i;
            rs1_1 <= rs1_i;
            rs2_1 <= rs2_i;
            f3_1  <= funct3_i;
            f7_1  <= funct7_i;
            imm1  <= imm_i;
            ill1  <= ill;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i || clear_i) begin
            v1          <= 1'b0;
            out_valid_o <= 1'b0;
            inst_o      <= '0;
            err_o       <= 1'b0;
            addr_o      <= BASE_ADDR;
            err_cnt_o   <= '0;
        end else begin
            if (in_ready_o) v1 <= in_valid_i;
            if (adv2) begin
                out_valid_o <= v1;
                err_o       <= v1 && ill1;
                if (v1) inst_o <= packed_w;
            end
            if (out_valid_o && out_ready_i) begin
                addr_o <= addr_o + ADDR_W'(4);
                if (err_o && err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed checks of packing, legality, backpressure, address wrap, reset/clear
// and a decoder round trip on random legal fields.
module tb_inst_encoder;
    logic        clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 1;
    logic [2:0]  sel = 0, f3 = 0;
    logic [6:0]  op = 0, f7 = 0;
    logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0;
    logic        in_ready, out_valid, err, in_ready4, out_valid4, err4;
    logic [31:0] inst, inst4;
    logic [13:0] addr;
    logic [3:0]  addr4;
    logic [7:0]  err_cnt, err_cnt4;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .imm_sel_i(sel), .opcode_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3),
        .funct7_i(f7), .imm_i(imm), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .inst_o(inst), .addr_o(addr), .err_o(err), .err_cnt_o(err_cnt)
    );

    inst_encoder #(.ADDR_W(4)) dut4 (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .imm_sel_i(sel), .opcode_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3),
        .funct7_i(f7), .imm_i(imm), .out_valid_o(out_valid4), .out_ready_i(out_ready),
        .inst_o(inst4), .addr_o(addr4), .err_o(err4), .err_cnt_o(err_cnt4)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] s, input logic [6:0] o, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] fn3,
                        input logic [6:0] fn7, input logic [31:0] im);
        sel = s; op = o; rd = d; rs1 = a; rs2 = b; f3 = fn3; f7 = fn7; imm = im;
        in_valid = 1;
    endtask

    task automatic addi(input int k);
        send(3'b001, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
    endtask

    task automatic do_clear;
        in_valid = 0; clr = 1;
        step;
        clr = 0;
    endtask

    function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] s);
        case (s)
            3'b001:  return {{20{i[31]}}, i[31:20]};
            3'b010:  return {27'd0, i[24:20]};
            3'b011:  return {{20{i[31]}}, i[31:25], i[11:7]};
            3'b100:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b101:  return {i[31:12], 12'd0};
            3'b110:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] r, lim;
        logic [2:0]  s;
        // reset state
        #2;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst inst", inst, 0);
        chk("rst err", 32'(err), 0);
        chk("rst addr", 32'(addr), 0);
        chk("rst err_cnt", 32'(err_cnt), 0);
        #11 rst = 0;
        step;
        chk("rst in_ready", 32'(in_ready), 1);
        // 1: I_ns addi x1,x0,5 with 2-cycle latency
        send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        step;
        in_valid = 0;
        chk("t1 latency", 32'(out_valid), 0);
        step;
        chk("t1 valid", 32'(out_valid), 1);
        chk("t1 inst", inst, 32'h00500093);
        chk("t1 addr", 32'(addr), 0);
        chk("t1 err", 32'(err), 0);
        step;
        // 2: B, J, U streamed
        send(3'b100, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8);
        step;
        send(3'b110, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        step;
        chk("t2 B inst", inst, 32'hFE208CE3);
        chk("t2 B addr", 32'(addr), 4);
        send(3'b101, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        step;
        chk("t2 J inst", inst, 32'h001000EF);
        chk("t2 J addr", 32'(addr), 8);
        in_valid = 0;
        step;
        chk("t2 U inst", inst, 32'h123452B7);
        chk("t2 U addr", 32'(addr), 12);
        step;
        chk("t2 drained", 32'(out_valid), 0);
        chk("t2 next addr", 32'(addr), 16);
        // 3: illegal inputs become NOPs and are counted
        send(3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step;
        send(3'b100, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        step;
        chk("t3 e1 inst", inst, 32'h13);
        chk("t3 e1 err", 32'(err), 1);
        chk("t3 e1 cnt", 32'(err_cnt), 0);
        send(3'b111, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        step;
        chk("t3 e2 inst", inst, 32'h13);
        chk("t3 e2 err", 32'(err), 1);
        chk("t3 e2 addr", 32'(addr), 20);
        chk("t3 e2 cnt", 32'(err_cnt), 1);
        in_valid = 0;
        step;
        chk("t3 e3 inst", inst, 32'h13);
        chk("t3 e3 err", 32'(err), 1);
        chk("t3 e3 cnt", 32'(err_cnt), 2);
        step;
        chk("t3 final cnt", 32'(err_cnt), 3);
        chk("t3 err drop", 32'(err), 0);
        // 4: backpressure
        do_clear;
        chk("clr addr", 32'(addr), 0);
        chk("clr err_cnt", 32'(err_cnt), 0);
        chk("clr out_valid", 32'(out_valid), 0);
        out_ready = 1;
        addi(1);
        step;
        addi(2);
        out_ready = 0;
        step;
        chk("t4 w0 inst", inst, 32'h00100093);
        chk("t4 w0 addr", 32'(addr), 0);
        chk("t4 in_ready low", 32'(in_ready), 0);
        addi(3);
        step;
        chk("t4 hold inst", inst, 32'h00100093);
        chk("t4 hold in_ready", 32'(in_ready), 0);
        step;
        chk("t4 hold valid", 32'(out_valid), 1);
        chk("t4 hold addr", 32'(addr), 0);
        out_ready = 1;
        step;
        chk("t4 w1 inst", inst, 32'h00200113);
        chk("t4 w1 addr", 32'(addr), 4);
        addi(4);
        step;
        chk("t4 w2 inst", inst, 32'h00300193);
        chk("t4 w2 addr", 32'(addr), 8);
        in_valid = 0;
        step;
        chk("t4 w3 inst", inst, 32'h00400213);
        chk("t4 w3 addr", 32'(addr), 12);
        step;
        chk("t4 drained", 32'(out_valid), 0);
        // 5: 4-bit address wraps
        do_clear;
        addi(1);
        step;
        for (int k = 2; k <= 6; k++) begin
            if (k <= 5) addi(k); else in_valid = 0;
            step;
            chk("t5 addr4", 32'(addr4), 32'(((k - 2) * 4) % 16));
            chk("t5 inst4", inst4, {12'(k - 1), 5'd0, 3'd0, 5'(k - 1), 7'h13});
        end
        step;
        // 6: async reset with two words in flight
        addi(7);
        step;
        addi(8);
        step;
        in_valid = 0;
        rst = 1;
        #2;
        chk("t6 rst valid", 32'(out_valid), 0);
        chk("t6 rst inst", inst, 0);
        chk("t6 rst addr", 32'(addr), 0);
        rst = 0;
        step;
        step;
        chk("t6 rst flushed", 32'(out_valid), 0);
        addi(9);
        step;
        in_valid = 0;
        step;
        chk("t6 post-rst inst", inst, 32'h00900493);
        chk("t6 post-rst addr", 32'(addr), 0);
        step;
        // 6: clear with two words in flight
        addi(10);
        step;
        addi(11);
        step;
        do_clear;
        chk("t6 clr valid", 32'(out_valid), 0);
        chk("t6 clr inst", inst, 0);
        chk("t6 clr addr", 32'(addr), 0);
        step;
        chk("t6 clr flushed", 32'(out_valid), 0);
        addi(12);
        step;
        in_valid = 0;
        step;
        chk("t6 post-clr inst", inst, 32'h00C00613);
        chk("t6 post-clr addr", 32'(addr), 0);
        step;
        // 7: random legal fields round trip through a decoder model
        for (int k = 0; k < 14; k++) begin
            r = $urandom;
            s = 3'(k % 7);
            case (s)
                3'b001, 3'b011: lim = {{20{r[11]}}, r[11:0]};
                3'b010:         lim = {27'd0, r[4:0]};
                3'b100:         lim = {{20{r[12]}}, r[11:1], 1'b0};
                3'b101:         lim = {r[31:12], 12'd0};
                3'b110:         lim = {{12{r[20]}}, r[19:1], 1'b0};
                default:        lim = r;
            endcase
            send(s, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 7'($urandom), lim);
            step;
            in_valid = 0;
            step;
            chk("t7 err", 32'(err), 0);
            chk("t7 opcode", 32'(inst[6:0]), 32'(op));
            if (s == 3'b000)
                chk("t7 R word", inst, {f7, rs2, rs1, f3, rd, op});
            else
                chk("t7 imm", decode(inst, s), lim);
            step;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
